// File: rtl/rgmii_speed_ctrl_if.sv
// Status/control bundle between the PHY status poller, the RGMII clock divider
// and the MAC reset.
//   status_valid  poller -> ctrl   one-cycle strobe, new PHY sample present
//   link_up       poller -> ctrl   PHY link state
//   phy_speed     poller -> ctrl   00=10M, 01=100M, 10=1G, 11=invalid
//   eth_speed     ctrl -> divider  applied speed select (same encoding)
//   mac_rst       ctrl -> MAC      active-high MAC reset
//   link_ok       ctrl -> system   link running at eth_speed
//   speed_chg     ctrl -> system   one-cycle pulse when eth_speed changes
interface rgmii_speed_ctrl_if;
    logic       status_valid;
    logic       link_up;
    logic [1:0] phy_speed;
    logic [1:0] eth_speed;
    logic       mac_rst;
    logic       link_ok;
    logic       speed_chg;

    // master: status poller side (drives samples, observes results)
    modport master (
        output status_valid, link_up, phy_speed,
        input  eth_speed, mac_rst, link_ok, speed_chg
    );

    // slave: the speed sequencer
    modport slave (
        input  status_valid, link_up, phy_speed,
        output eth_speed, mac_rst, link_ok, speed_chg
    );
endinterface

// File: rtl/rgmii_speed_ctrl.sv
// Link-speed sequencer for the RGMII MAC clock divider. Qualifies PHY
// link/speed samples, holds the MAC in reset while the divider select changes,
// waits for the divided clock to settle and then releases the MAC.
// Ports:
//   clk    125 MHz reference clock
//   reset  synchronous, active-high
//   bus    rgmii_speed_ctrl_if.slave (status in, eth_speed/mac_rst/link_ok/speed_chg out)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// LINK_DOWN | no usable link, MAC held in reset, waiting for a good sample
// QUALIFY   | counting consecutive good samples at the same candidate speed
// APPLY     | one cycle: drive candidate onto eth_speed, restart settle timer
// SETTLE    | divided clock settling, MAC still in reset
// RUN       | MAC released, link_ok asserted
module rgmii_speed_ctrl #(
    parameter int QUAL_COUNT    = 4,
    parameter int SETTLE_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    rgmii_speed_ctrl_if.slave    bus
);

    localparam int QCW = $clog2(QUAL_COUNT + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES);

    localparam logic [QCW-1:0] QUAL_MAX    = QCW'(QUAL_COUNT);
    localparam logic [QCW-1:0] QUAL_ONE    = QCW'(1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    localparam logic [2:0] LINK_DOWN = 3'd0;
    localparam logic [2:0] QUALIFY   = 3'd1;
    localparam logic [2:0] APPLY     = 3'd2;
    localparam logic [2:0] SETTLE    = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;

    // With a single-sample qualification the first good sample is already final.
    localparam logic [2:0] FIRST_GOOD_NEXT = (QUAL_COUNT == 1) ? APPLY : QUALIFY;

    localparam logic [1:0] SPEED_1G      = 2'b10;
    localparam logic [1:0] SPEED_INVALID = 2'b11;

    logic [2:0]     state_q,      state_d;
    logic [1:0]     eth_speed_q,  eth_speed_d;
    logic           mac_rst_q,    mac_rst_d;
    logic           link_ok_q,    link_ok_d;
    logic           speed_chg_q,  speed_chg_d;
    logic [1:0]     cand_q,       cand_d;
    logic [QCW-1:0] qual_cnt_q,   qual_cnt_d;
    logic [SCW-1:0] settle_cnt_q, settle_cnt_d;

    logic good_smp;
    logic bad_smp;

    assign good_smp = bus.status_valid &  bus.link_up & (bus.phy_speed != SPEED_INVALID);
    assign bad_smp  = bus.status_valid & (~bus.link_up | (bus.phy_speed == SPEED_INVALID));

    always_comb begin
        state_d      = state_q;
        eth_speed_d  = eth_speed_q;
        mac_rst_d    = mac_rst_q;
        link_ok_d    = link_ok_q;
        speed_chg_d  = 1'b0;
        cand_d       = cand_q;
        qual_cnt_d   = qual_cnt_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            LINK_DOWN: begin
                mac_rst_d = 1'b1;
                link_ok_d = 1'b0;
                if (good_smp) begin
                    cand_d     = bus.phy_speed;
                    qual_cnt_d = QUAL_ONE;
                    state_d    = FIRST_GOOD_NEXT;
                end
            end

            QUALIFY: begin
                mac_rst_d = 1'b1;
                link_ok_d = 1'b0;
                if (bad_smp) begin
                    qual_cnt_d = '0;
                    state_d    = LINK_DOWN;
                end else if (good_smp) begin
                    if (bus.phy_speed == cand_q) begin
                        if (qual_cnt_q != QUAL_MAX) begin
                            qual_cnt_d = qual_cnt_q + QUAL_ONE;
                        end
                        // this sample brings the count to QUAL_COUNT
                        if (qual_cnt_q >= QUAL_MAX - QUAL_ONE) begin
                            state_d = APPLY;
                        end
                    end else begin
                        cand_d     = bus.phy_speed;
                        qual_cnt_d = QUAL_ONE;
                    end
                end
            end

            APPLY: begin
                mac_rst_d    = 1'b1;
                link_ok_d    = 1'b0;
                eth_speed_d  = cand_q;
                speed_chg_d  = (cand_q != eth_speed_q);
                settle_cnt_d = '0;
                state_d      = SETTLE;
            end

            SETTLE: begin
                mac_rst_d = 1'b1;
                link_ok_d = 1'b0;
                if (settle_cnt_q != SETTLE_LAST) begin
                    settle_cnt_d = settle_cnt_q + SCW'(1);
                end
                // a link drop wins over completing the settle period
                if (bad_smp) begin
                    state_d = LINK_DOWN;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    mac_rst_d = 1'b0;
                    link_ok_d = 1'b1;
                    state_d   = RUN;
                end
            end

            RUN: begin
                if (bad_smp) begin
                    mac_rst_d = 1'b1;
                    link_ok_d = 1'b0;
                    state_d   = LINK_DOWN;
                end else if (good_smp && (bus.phy_speed != eth_speed_q)) begin
                    mac_rst_d  = 1'b1;
                    link_ok_d  = 1'b0;
                    cand_d     = bus.phy_speed;
                    qual_cnt_d = QUAL_ONE;
                    state_d    = FIRST_GOOD_NEXT;
                end
            end

            default: begin
                mac_rst_d = 1'b1;
                link_ok_d = 1'b0;
                state_d   = LINK_DOWN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LINK_DOWN;
            eth_speed_q  <= SPEED_1G;
            mac_rst_q    <= 1'b1;
            link_ok_q    <= 1'b0;
            speed_chg_q  <= 1'b0;
            cand_q       <= SPEED_1G;
            qual_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            eth_speed_q  <= eth_speed_d;
            mac_rst_q    <= mac_rst_d;
            link_ok_q    <= link_ok_d;
            speed_chg_q  <= speed_chg_d;
            cand_q       <= cand_d;
            qual_cnt_q   <= qual_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign bus.eth_speed = eth_speed_q;
    assign bus.mac_rst   = mac_rst_q;
    assign bus.link_ok   = link_ok_q;
    assign bus.speed_chg = speed_chg_q;

endmodule

// File: tb/tb_rgmii_speed_ctrl.sv
// Bench for rgmii_speed_ctrl (QUAL_COUNT=4, SETTLE_CYCLES=256).
// Short sequences come from a vector table pushed through a scoreboard queue;
// the long settle/abort/reset cases are hand-written sequences.
module tb_rgmii_speed_ctrl;

    typedef struct {
        logic       rst;
        logic       sv;
        logic       lu;
        logic [1:0] sp;
        logic [1:0] e_eth;
        logic       e_rst;
        logic       e_ok;
        logic       e_chg;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    vec_t tbl[$];
    vec_t sb[$];

    rgmii_speed_ctrl_if bus ();

    rgmii_speed_ctrl #(
        .QUAL_COUNT    (4),
        .SETTLE_CYCLES (256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // eth_speed must never show the invalid code
    always @(negedge clk) begin
        total++;
        if (bus.eth_speed === 2'b11) begin
            bad++;
            $display("FAIL eth_never_11: got=%b required!=11 t=%0t", bus.eth_speed, $time);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic s, input logic l, input logic [1:0] p,
                                input logic [1:0] ee, input logic er, input logic eo, input logic ec);
        vec_t v;
        v.rst = r; v.sv = s; v.lu = l; v.sp = p;
        v.e_eth = ee; v.e_rst = er; v.e_ok = eo; v.e_chg = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b required=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input logic [1:0] eth, input logic r,
                           input logic ok, input logic chg);
        chk({nm, ".eth_speed"}, bus.eth_speed, eth);
        chk({nm, ".mac_rst"},   {1'b0, bus.mac_rst},   {1'b0, r});
        chk({nm, ".link_ok"},   {1'b0, bus.link_ok},   {1'b0, ok});
        chk({nm, ".speed_chg"}, {1'b0, bus.speed_chg}, {1'b0, chg});
    endtask

    task automatic run_vecs(input int lo, input int hi, input string seg);
        vec_t v;
        for (int i = lo; i < hi; i++) begin
            reset            = tbl[i].rst;
            bus.status_valid = tbl[i].sv;
            bus.link_up      = tbl[i].lu;
            bus.phy_speed    = tbl[i].sp;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            v = sb.pop_front();
            chk_out($sformatf("%s[%0d]", seg, i - lo), v.e_eth, v.e_rst, v.e_ok, v.e_chg);
        end
        reset            = 1'b0;
        bus.status_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        reset            = 1'b0;
        bus.status_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic lu, input logic [1:0] sp);
        reset            = 1'b0;
        bus.status_valid = 1'b1;
        bus.link_up      = lu;
        bus.phy_speed    = sp;
        @(posedge clk);
        #1;
        bus.status_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset            = 1'b1;
        bus.status_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_run(input string nm, input int budget);
        int n;
        n = 0;
        while (bus.mac_rst === 1'b1 && n < budget) begin
            idle(1);
            n++;
        end
        chk({nm, ".reached_run"}, {1'b0, bus.mac_rst}, 2'b00);
    endtask

    int seg_a, seg_b, seg_c;

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        bus.status_valid = 1'b0;
        bus.link_up      = 1'b0;
        bus.phy_speed    = 2'b00;

        // segment A: reset then four good 01 samples
        tbl.push_back(mk(1, 0, 0, 2'b00, 2'b10, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 2'b01, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b01, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b01, 1, 0, 0));
        seg_a = tbl.size();
        // segment B: 01,01,00,(ignored noise),00,00,00 -> restart on first 00
        tbl.push_back(mk(1, 0, 0, 2'b00, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b01, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b01, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b00, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b11, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b00, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b00, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b00, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 1, 0, 1));
        seg_b = tbl.size();
        // segment C: invalid speed in QUALIFY drops to LINK_DOWN, count restarts
        tbl.push_back(mk(1, 0, 0, 2'b00, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b01, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b01, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b11, 2'b10, 1, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 1, 2'b01, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2'b01, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 2'b01, 1, 0, 1));
        seg_c = tbl.size();

        // 1: first bring-up at 01, mac_rst falls exactly 257 cycles after the 4th sample
        run_vecs(0, seg_a, "bringup");
        idle(254);
        chk_out("settle_last", 2'b01, 1, 0, 0);
        idle(1);
        chk_out("settle_done", 2'b01, 0, 1, 0);

        // 2: qualification restart
        run_vecs(seg_a, seg_b, "restart");
        wait_run("restart", 300);
        chk_out("restart_run", 2'b00, 0, 1, 0);
        sample(1, 2'b00);
        chk_out("run_same_speed", 2'b00, 0, 1, 0);

        // 5: invalid speed in QUALIFY and in RUN
        run_vecs(seg_b, seg_c, "inval_q");
        wait_run("inval_q", 300);
        sample(1, 2'b11);
        chk_out("inval_run", 2'b01, 1, 0, 0);
        idle(300);
        chk_out("inval_run_hold", 2'b01, 1, 0, 0);

        // 3: running at 10, move to 00
        pulse_reset();
        for (int i = 0; i < 4; i++) sample(1, 2'b10);
        idle(1);
        chk_out("same_speed_apply", 2'b10, 1, 0, 0);
        wait_run("run10", 300);
        chk_out("run10", 2'b10, 0, 1, 0);
        sample(1, 2'b00);
        chk_out("run10_leave", 2'b10, 1, 0, 0);
        for (int i = 0; i < 3; i++) sample(1, 2'b00);
        chk_out("to00_pre", 2'b10, 1, 0, 0);
        idle(1);
        chk_out("to00_apply", 2'b00, 1, 0, 1);
        wait_run("run00", 300);
        chk_out("run00", 2'b00, 0, 1, 0);

        // 4: link drop at settle_cnt=100 aborts the settle
        for (int i = 0; i < 4; i++) sample(1, 2'b10);
        idle(1);
        chk_out("abort_apply", 2'b10, 1, 0, 1);
        idle(100);
        sample(0, 2'b10);
        chk_out("abort", 2'b10, 1, 0, 0);
        idle(300);
        chk_out("abort_hold", 2'b10, 1, 0, 0);

        // 6: reset mid-SETTLE, reset during APPLY, then normal requalification
        for (int i = 0; i < 4; i++) sample(1, 2'b00);
        idle(1);
        chk_out("r6_apply", 2'b00, 1, 0, 1);
        idle(50);
        pulse_reset();
        chk_out("r6_mid_settle", 2'b10, 1, 0, 0);
        for (int i = 0; i < 4; i++) sample(1, 2'b01);
        pulse_reset();
        chk_out("r6_inflight", 2'b10, 1, 0, 0);
        for (int i = 0; i < 4; i++) sample(1, 2'b01);
        idle(1);
        chk_out("r6_requal", 2'b01, 1, 0, 1);
        wait_run("r6", 300);
        chk_out("r6_run", 2'b01, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
